harness_cmd_engine: RTL and testbench

Synthesizable command interpreter that forms the device side of the simulation-harness byte protocol. It consumes the same single-byte command stream the host already issues: `h` read outputs, `i` quit, `j`/`k` reset control, `l` step, `m` load inputs. It drives a wrapped DUT's inputs, reset and clock-enable, and serializes the DUT's outputs back as raw bytes. It sits between a byte transport (UART/JTAG FIFO) and a compiled DUT running on a clock-enable.

---
 rtl/harness_cmd_engine.sv | 172 +++++++++++++++++
 tb/tb_harness_cmd_engine.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/harness_cmd_engine.sv
// Device side of the simulation-harness byte protocol: decodes single-byte
// commands, drives a wrapped DUT's inputs/reset/step and streams its outputs back.
`timescale 1ns/1ps
module harness_cmd_engine #(
  parameter int INPUT_SIZE   = 32,
  parameter int OUTPUT_SIZE  = 32,
  parameter int INPUT_BYTES  = (INPUT_SIZE + 7) / 8,
  parameter int OUTPUT_WORDS = (OUTPUT_SIZE + 31) / 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [INPUT_SIZE-1:0]  data_in,
  input  logic [OUTPUT_SIZE-1:0] data_out,
  output logic                   dut_rst,
  output logic                   dut_step,
  output logic                   halted,
  output logic                   error,
  output logic [7:0]             error_byte,
  output logic [2:0]             dbg_state
);

  // Handshakes: a byte moves on rx when rx_valid & rx_ready at a rising edge,
  // and on tx when tx_valid & tx_ready at a rising edge; tx_data holds while stalled.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  localparam int SHADOW_W   = 8 * INPUT_BYTES;
  localparam int SNAP_W     = 32 * OUTPUT_WORDS;
  localparam int SEND_BYTES = 4 * OUTPUT_WORDS;
  localparam int CNT_W      = (INPUT_BYTES > 1) ? $clog2(INPUT_BYTES) : 1;
  localparam int IDX_W      = $clog2(SEND_BYTES);

  localparam logic [7:0] CMD_READ  = 8'h68;
  localparam logic [7:0] CMD_QUIT  = 8'h69;
  localparam logic [7:0] CMD_RSTON = 8'h6A;
  localparam logic [7:0] CMD_RSTOF = 8'h6B;
  localparam logic [7:0] CMD_STEP  = 8'h6C;
  localparam logic [7:0] CMD_LOAD  = 8'h6D;

  state_t                  state_q, state_d;
  logic [SHADOW_W-1:0]     shadow_q, shadow_d, shadow_shift;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SNAP_W-1:0]       snap_q, snap_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [INPUT_SIZE-1:0]   data_in_q, data_in_d;
  logic                    dut_rst_q, dut_rst_d;
  logic                    step_q, step_d;
  logic                    error_q, error_d;
  logic [7:0]              errb_q, errb_d;
  logic                    rx_fire;

  assign rx_ready   = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_HALTED);
  assign rx_fire    = rx_valid && rx_ready;
  assign tx_valid   = (state_q == S_SEND);
  assign tx_data    = snap_q[{idx_q, 3'b000} +: 8];
  assign data_in    = data_in_q;
  assign dut_rst    = dut_rst_q;
  assign dut_step   = step_q;
  assign halted     = (state_q == S_HALTED);
  assign error      = error_q;
  assign error_byte = errb_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    cnt_d        = cnt_q;
    snap_d       = snap_q;
    idx_d        = idx_q;
    data_in_d    = data_in_q;
    dut_rst_d    = dut_rst_q;
    step_d       = 1'b0;
    error_d      = error_q;
    errb_d       = errb_q;
    // New byte enters at the top so the first byte ends at the bottom.
    shadow_shift = shadow_q >> 8;
    shadow_shift[SHADOW_W-1 -: 8] = rx_data;

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          case (rx_data)
            CMD_READ:  state_d = S_CAPTURE;
            CMD_QUIT:  state_d = S_HALTED;
            CMD_RSTON: dut_rst_d = 1'b1;
            CMD_RSTOF: dut_rst_d = 1'b0;
            CMD_STEP:  step_d = 1'b1;
            CMD_LOAD: begin
              state_d = S_LOAD;
              cnt_d   = '0;
            end
            default: begin
              error_d = 1'b1;
              errb_d  = rx_data;
              state_d = S_HALTED;
            end
          endcase
        end
      end
      S_LOAD: begin
        if (rx_fire) begin
          shadow_d = shadow_shift;
          if (cnt_q == CNT_W'(INPUT_BYTES - 1)) begin
            data_in_d = shadow_shift[INPUT_SIZE-1:0];
            cnt_d     = '0;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        snap_d  = SNAP_W'(data_out);
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          if (idx_q == IDX_W'(SEND_BYTES - 1)) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      cnt_q     <= '0;
      snap_q    <= '0;
      idx_q     <= '0;
      data_in_q <= '0;
      dut_rst_q <= 1'b1;
      step_q    <= 1'b0;
      error_q   <= 1'b0;
      errb_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      data_in_q <= data_in_d;
      dut_rst_q <= dut_rst_d;
      step_q    <= step_d;
      error_q   <= error_d;
      errb_q    <= errb_d;
    end
  end

endmodule

// File: tb/tb_harness_cmd_engine.sv
// Directed bench for harness_cmd_engine with 16-bit inputs and 40-bit outputs.
`timescale 1ns/1ps
module tb_harness_cmd_engine;

  localparam int IS = 16;
  localparam int OS = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [IS-1:0] data_in;
  logic [OS-1:0] data_out = '0;
  logic          dut_rst, dut_step, halted, error;
  logic [7:0]    error_byte;
  logic [2:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  harness_cmd_engine #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .data_in(data_in), .data_out(data_out),
    .dut_rst(dut_rst), .dut_step(dut_step),
    .halted(halted), .error(error), .error_byte(error_byte),
    .dbg_state(dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte's accept edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  b;
    logic        exp_rst;
    logic        exp_step;
    logic [15:0] exp_din;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [7:0] held;
    logic       stalled;
    int         k;
    int         cycles;

    vecs[0]  = '{8'h6B, 1'b0, 1'b0, 16'h0000}; // k
    vecs[1]  = '{8'h6C, 1'b0, 1'b1, 16'h0000}; // l
    vecs[2]  = '{8'h6C, 1'b0, 1'b1, 16'h0000}; // l back-to-back
    vecs[3]  = '{8'h6A, 1'b1, 1'b0, 16'h0000}; // j
    vecs[4]  = '{8'h6B, 1'b0, 1'b0, 16'h0000}; // k
    vecs[5]  = '{8'h6D, 1'b0, 1'b0, 16'h0000}; // m
    vecs[6]  = '{8'h34, 1'b0, 1'b0, 16'h0000};
    vecs[7]  = '{8'h12, 1'b0, 1'b0, 16'h1234};
    vecs[8]  = '{8'h6D, 1'b0, 1'b0, 16'h1234}; // m
    vecs[9]  = '{8'hCD, 1'b0, 1'b0, 16'h1234};
    vecs[10] = '{8'hAB, 1'b0, 1'b0, 16'hABCD};

    @(negedge clk);
    do_reset();

    chk("rst_dut_rst", dut_rst, 1);
    chk("rst_dut_step", dut_step, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_halted", halted, 0);
    chk("rst_error", error, 0);
    chk("rst_error_byte", error_byte, 0);
    chk("rst_rx_ready", rx_ready, 1);

    for (int i = 0; i < 11; i++) begin
      send_byte(vecs[i].b);
      chk($sformatf("vec%0d_dut_rst", i), dut_rst, vecs[i].exp_rst);
      chk($sformatf("vec%0d_dut_step", i), dut_step, vecs[i].exp_step);
      chk($sformatf("vec%0d_data_in", i), data_in, vecs[i].exp_din);
      chk($sformatf("vec%0d_rx_ready", i), rx_ready, 1);
    end
    @(negedge clk);
    chk("idle_step_low", dut_step, 0);

    // Readback with tx_ready pattern 1,0,0,1,0,0...
    data_out = 40'hAB_DEADBEEF;
    exp_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hAB, 8'h00, 8'h00, 8'h00};
    send_byte(8'h68);
    chk("capture_rx_ready", rx_ready, 0);
    chk("capture_tx_valid", tx_valid, 0);
    k = 0; cycles = 0; stalled = 1'b0; held = 8'h00;
    while (exp_q.size() > 0 && cycles < 100) begin
      if (tx_valid) begin
        chk("send_rx_ready", rx_ready, 0);
        if (stalled) chk("send_hold", tx_data, held);
        tx_ready = (k % 3 == 0);
        if (tx_ready) begin
          chk("send_byte", tx_data, exp_q.pop_front());
          stalled = 1'b0;
        end else begin
          held = tx_data;
          stalled = 1'b1;
        end
        k++;
      end
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    chk("send_remaining", exp_q.size(), 0);
    tx_ready = 1'b0;
    chk("send_done_tx_valid", tx_valid, 0);
    chk("send_done_rx_ready", rx_ready, 1);

    // Reset while a send is stalled
    send_byte(8'h68);
    @(negedge clk);
    chk("abort_tx_valid_before", tx_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_tx_data", tx_data, 0);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("abort_no_resume", tx_valid, 0);
    tx_ready = 1'b0;

    // Unknown command
    send_byte(8'h6B);
    send_byte(8'h41);
    chk("unk_error", error, 1);
    chk("unk_error_byte", error_byte, 8'h41);
    chk("unk_halted", halted, 1);
    chk("unk_rx_ready", rx_ready, 1);
    send_byte(8'h6C);
    chk("unk_step0", dut_step, 0);
    chk("unk_dut_rst", dut_rst, 0);
    @(negedge clk);
    chk("unk_step1", dut_step, 0);

    // Quit then j
    do_reset();
    send_byte(8'h6B);
    send_byte(8'h69);
    chk("quit_halted", halted, 1);
    chk("quit_error", error, 0);
    send_byte(8'h6A);
    @(negedge clk);
    chk("quit_dut_rst", dut_rst, 0);
    chk("quit_error_after", error, 0);

    // Reset mid-load
    do_reset();
    send_byte(8'h6D); send_byte(8'h77); send_byte(8'h66);
    chk("pre_load", data_in, 16'h6677);
    send_byte(8'h6D); send_byte(8'h55);
    chk("midload_hold", data_in, 16'h6677);
    do_reset();
    chk("midload_rst", data_in, 0);
    send_byte(8'h6D);
    send_byte(8'h01);
    chk("reload_partial", data_in, 0);
    send_byte(8'h02);
    chk("reload_full", data_in, 16'h0201);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
